// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS forwarding/hazard unit
package mips_pkg;

    // Destination field is wide enough for any register file up to 256 entries;
    // narrower register addresses are zero-extended into it.
    localparam int HIST_DEST_W = 8;

    // Forward select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                   valid;
        logic [HIST_DEST_W-1:0] dest;
        logic                   reg_write;
        logic                   is_load;
    } hist_entry_t;

    localparam hist_entry_t HIST_BUBBLE = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/fwd_match.sv
// rtl/fwd_match.sv - youngest in-flight producer lookup for one source operand
module fwd_match
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic [REG_ADDR_W-1:0] i_src,
    input  hist_entry_t           i_hist [0:DEPTH],
    output logic [SEL_W-1:0]      o_idx,
    output logic [SEL_W-1:0]      o_sel,
    output logic                  o_is_load
);

    logic [HIST_DEST_W-1:0] w_src_ext;

    assign w_src_ext = HIST_DEST_W'(i_src);

    // Scan oldest to youngest so the youngest matching entry is the last one written.
    always_comb begin
        o_idx     = '0;
        o_sel     = SEL_W'(FWD_RF);
        o_is_load = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_hist[i].valid && i_hist[i].reg_write &&
                (i_hist[i].dest == w_src_ext) && (w_src_ext != '0)) begin
                o_idx     = SEL_W'(i);
                o_sel     = SEL_W'(i + 1);
                o_is_load = i_hist[i].is_load;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding selects, load-use stall and memory freeze
module fwd_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [REG_ADDR_W-1:0]         id_dest,
    input  logic                          id_reg_write,
    input  logic                          id_mem_read,
    input  logic                          mem_ready,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic                          freeze,
    output logic [15:0]                   stall_count
);

    // hist[0] is the instruction in EX, hist[i] the one held in forwarding latch i.
    hist_entry_t              r_hist [0:DEPTH];
    logic [NUM_SRC*SEL_W-1:0] r_fwd_sel;
    fsm_state_t               r_state;
    logic [15:0]              r_stall_count;

    fsm_state_t               w_state_nxt;
    logic [NUM_SRC*SEL_W-1:0] w_cand_sel;
    logic [NUM_SRC-1:0]       w_src_hazard;
    logic                     w_hazard;
    logic                     w_freeze;
    logic                     w_stall;
    logic                     w_issue;
    hist_entry_t              w_id_entry;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [SEL_W-1:0] w_idx;
        logic             w_is_load;

        fwd_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .SEL_W      (SEL_W)
        ) u_match (
            .i_src      (id_src[s*REG_ADDR_W +: REG_ADDR_W]),
            .i_hist     (r_hist),
            .o_idx      (w_idx),
            .o_sel      (w_cand_sel[s*SEL_W +: SEL_W]),
            .o_is_load  (w_is_load)
        );

        // Load data is not forwardable until it reaches latch LOAD_STAGE.
        assign w_src_hazard[s] = w_is_load && ((int'(w_idx) + 1) < LOAD_STAGE);
    end

    assign w_hazard = id_valid & (|w_src_hazard);
    assign w_freeze = r_hist[1].valid & r_hist[1].is_load & ~mem_ready;
    assign w_stall  = w_hazard & ~w_freeze;
    assign w_issue  = id_valid & ~w_stall;

    // Pack the ID instruction into a history entry.
    always_comb begin
        w_id_entry           = HIST_BUBBLE;
        w_id_entry.valid     = 1'b1;
        w_id_entry.dest      = HIST_DEST_W'(id_dest);
        w_id_entry.reg_write = id_reg_write;
        w_id_entry.is_load   = id_mem_read;
    end

    // Shift the shadow history and register the forward selects unless frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= DEPTH; i++) begin
                r_hist[i] <= HIST_BUBBLE;
            end
            r_fwd_sel <= '0;
        end else if (!w_freeze) begin
            for (int i = DEPTH; i >= 1; i--) begin
                r_hist[i] <= r_hist[i-1];
            end
            r_hist[0] <= w_issue ? w_id_entry : HIST_BUBBLE;
            r_fwd_sel <= w_issue ? w_cand_sel : '0;
        end
    end

    // Next hazard state; freeze outranks a coincident load-use stall.
    always_comb begin
        w_state_nxt = RUN;
        case (r_state)
            RUN: begin
                if (w_freeze)     w_state_nxt = MEM_WAIT;
                else if (w_stall) w_state_nxt = LD_STALL;
                else              w_state_nxt = RUN;
            end
            LD_STALL: begin
                if (w_freeze)     w_state_nxt = MEM_WAIT;
                else if (w_stall) w_state_nxt = LD_STALL;
                else              w_state_nxt = RUN;
            end
            MEM_WAIT: begin
                if (w_freeze)     w_state_nxt = MEM_WAIT;
                else if (w_stall) w_state_nxt = LD_STALL;
                else              w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // State register and saturating count of cycles spent stalled or frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != RUN) && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign fwd_sel     = r_fwd_sel;
    assign stall       = w_stall;
    assign freeze      = w_freeze;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed and randomized checks of fwd_hazard_unit against a reference model
module tb_fwd_hazard_unit;

    localparam int RAW   = 5;
    localparam int NS    = 2;
    localparam int DEPTH = 2;
    localparam int LS    = 2;
    localparam int SW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [NS*RAW-1:0] id_src;
    logic [RAW-1:0]    id_dest;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              mem_ready;
    logic [NS*SW-1:0]  fwd_sel;
    logic              stall;
    logic              freeze;
    logic [15:0]       stall_count;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .REG_ADDR_W (RAW),
        .NUM_SRC    (NS),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .mem_ready    (mem_ready),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .freeze       (freeze),
        .stall_count  (stall_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a plain list of in-flight instructions, youngest first.
    bit m_v    [0:DEPTH];
    int m_dest [0:DEPTH];
    bit m_rw   [0:DEPTH];
    bit m_ld   [0:DEPTH];
    int m_sel  [NS];
    int m_cnt;
    bit e_stall;
    bit e_freeze;
    int e_sel  [NS];
    int cur_src[NS];

    task automatic model_clear();
        for (int i = 0; i <= DEPTH; i++) begin
            m_v[i] = 0; m_dest[i] = 0; m_rw[i] = 0; m_ld[i] = 0;
        end
        for (int s = 0; s < NS; s++) m_sel[s] = 0;
        m_cnt = 0;
    endtask

    function automatic int youngest(input int r);
        if (r == 0) return -1;
        for (int i = 0; i < DEPTH; i++)
            if (m_v[i] && m_rw[i] && m_dest[i] == r) return i;
        return -1;
    endfunction

    task automatic predict();
        bit hz = 0;
        for (int s = 0; s < NS; s++) begin
            int y = youngest(cur_src[s]);
            e_sel[s] = y + 1;
            if (y >= 0 && m_ld[y] && (y + 1) < LS) hz = 1;
        end
        e_freeze = m_v[1] && m_ld[1] && !mem_ready;
        e_stall  = id_valid && hz && !e_freeze;
    endtask

    // Drive one ID cycle, then compare every output against the model at the falling edge.
    task automatic cyc(input bit v, input int s0, input int s1, input int d,
                       input bit rw, input bit ld, input bit mr);
        id_valid     = v;
        cur_src[0]   = s0;
        cur_src[1]   = s1;
        id_src       = {RAW'(s1), RAW'(s0)};
        id_dest      = RAW'(d);
        id_reg_write = rw;
        id_mem_read  = ld;
        mem_ready    = mr;
        @(negedge clk);
        predict();
        check_eq("stall", {31'd0, stall}, {31'd0, e_stall});
        check_eq("freeze", {31'd0, freeze}, {31'd0, e_freeze});
        for (int s = 0; s < NS; s++)
            check_eq($sformatf("fwd_sel%0d", s), 32'(fwd_sel[s*SW +: SW]), m_sel[s]);
        check_eq("stall_count", {16'd0, stall_count}, m_cnt);
    endtask

    // Clock edge: advance the model with the same inputs the DUT saw.
    task automatic adv();
        if (rst) begin
            model_clear();
        end else begin
            if (e_stall || e_freeze) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            if (!e_freeze) begin
                bit iss = id_valid && !e_stall;
                for (int i = DEPTH; i >= 1; i--) begin
                    m_v[i] = m_v[i-1]; m_dest[i] = m_dest[i-1];
                    m_rw[i] = m_rw[i-1]; m_ld[i] = m_ld[i-1];
                end
                m_v[0]    = iss;
                m_dest[0] = int'(id_dest);
                m_rw[0]   = id_reg_write;
                m_ld[0]   = id_mem_read;
                for (int s = 0; s < NS; s++) m_sel[s] = iss ? e_sel[s] : 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic flush();
        repeat (DEPTH + 1) begin nop(); adv(); end
    endtask

    int r_v, r_s0, r_s1, r_d, r_rw, r_ld;

    initial begin
        rst = 1'b1;
        id_valid = 0; id_src = '0; id_dest = '0; id_reg_write = 0; id_mem_read = 0; mem_ready = 1;
        cur_src[0] = 0; cur_src[1] = 0;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        nop();
        check_eq("rst_fwd_sel", 32'(fwd_sel), 0);
        check_eq("rst_count", {16'd0, stall_count}, 0);
        adv();

        // add $3 ; sub ..,$3,$4
        cyc(1, 0, 0, 3, 1, 0, 1); adv();
        cyc(1, 3, 4, 7, 1, 0, 1); check_eq("A_stall", {31'd0, stall}, 0); adv();
        nop();
        check_eq("A_sel0", 32'(fwd_sel[0 +: SW]), 1);
        check_eq("A_sel1", 32'(fwd_sel[SW +: SW]), 0);
        adv(); flush();

        // add $3 ; nop ; or ..,$3,$3
        cyc(1, 0, 0, 3, 1, 0, 1); adv();
        nop(); adv();
        cyc(1, 3, 3, 8, 1, 0, 1); adv();
        nop();
        check_eq("B_sel0", 32'(fwd_sel[0 +: SW]), 2);
        check_eq("B_sel1", 32'(fwd_sel[SW +: SW]), 2);
        adv(); flush();

        // add $3 ; add $3 ; use $3 -> youngest wins
        cyc(1, 0, 0, 3, 1, 0, 1); adv();
        cyc(1, 0, 0, 3, 1, 0, 1); adv();
        cyc(1, 3, 0, 8, 1, 0, 1); adv();
        nop(); check_eq("C_sel0", 32'(fwd_sel[0 +: SW]), 1); adv(); flush();

        // lw $5 ; and ..,$5,$6
        cyc(1, 0, 0, 5, 1, 1, 1); adv();
        cyc(1, 5, 6, 9, 1, 0, 1); check_eq("D_stall1", {31'd0, stall}, 1); adv();
        cyc(1, 5, 6, 9, 1, 0, 1); check_eq("D_stall2", {31'd0, stall}, 0); adv();
        nop();
        check_eq("D_sel0", 32'(fwd_sel[0 +: SW]), 2);
        check_eq("D_count", {16'd0, stall_count}, 1);
        adv(); flush();

        // writes to $0 then use of $0
        cyc(1, 0, 0, 0, 1, 1, 1); adv();
        cyc(1, 0, 0, 0, 1, 0, 1); check_eq("E_stall", {31'd0, stall}, 0); adv();
        nop(); check_eq("E_sel", 32'(fwd_sel), 0); adv(); flush();

        // freeze for 3 cycles with lw in MEM and a dependent instruction in ID
        rst = 1'b1; nop(); adv(); rst = 1'b0;
        cyc(1, 0, 0, 9, 1, 0, 1); adv();
        cyc(1, 0, 0, 5, 1, 1, 1); adv();
        cyc(1, 9, 0, 10, 1, 0, 1); adv();
        for (int k = 0; k < 3; k++) begin
            cyc(1, 5, 0, 11, 1, 0, 0);
            check_eq("F_freeze", {31'd0, freeze}, 1);
            check_eq("F_stall", {31'd0, stall}, 0);
            check_eq("F_hold_sel0", 32'(fwd_sel[0 +: SW]), 2);
            adv();
        end
        cyc(1, 5, 0, 11, 1, 0, 1); check_eq("F_release", {31'd0, freeze}, 0); adv();
        nop();
        check_eq("F_dep_sel0", 32'(fwd_sel[0 +: SW]), 2);
        check_eq("F_count", {16'd0, stall_count}, 3);
        adv(); flush();

        // reset asserted during a freeze
        cyc(1, 0, 0, 5, 1, 1, 1); adv();
        cyc(1, 0, 0, 10, 1, 0, 1); adv();
        cyc(1, 5, 0, 11, 1, 0, 0); check_eq("G_freeze", {31'd0, freeze}, 1); adv();
        rst = 1'b1;
        cyc(1, 5, 0, 11, 1, 0, 0); adv();
        rst = 1'b0;
        cyc(1, 5, 0, 11, 1, 0, 0);
        check_eq("G_freeze0", {31'd0, freeze}, 0);
        check_eq("G_stall0", {31'd0, stall}, 0);
        check_eq("G_sel0", 32'(fwd_sel), 0);
        check_eq("G_count0", {16'd0, stall_count}, 0);
        adv();

        // randomized traffic; ID holds its instruction while stalled or frozen
        r_v = 0; r_s0 = 0; r_s1 = 0; r_d = 0; r_rw = 0; r_ld = 0;
        e_stall = 0; e_freeze = 0;
        for (int n = 0; n < 800; n++) begin
            if (!(e_stall || e_freeze)) begin
                r_v  = ($urandom_range(0, 3) != 0);
                r_s0 = $urandom_range(0, 7);
                r_s1 = $urandom_range(0, 7);
                r_d  = $urandom_range(0, 7);
                r_rw = ($urandom_range(0, 4) != 0);
                r_ld = ($urandom_range(0, 2) == 0);
            end
            rst = ($urandom_range(0, 199) == 0);
            cyc(r_v[0], r_s0, r_s1, r_d, r_rw[0], r_ld[0], $urandom_range(0, 9) > 2);
            adv();
            if (rst) begin e_stall = 0; e_freeze = 0; end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
